// File: rtl/pipe_idex_hs_reg.sv
// pipe_idex_hs_reg -- ID->EX pipeline register with a valid/ready handshake
// and a 2-entry skid buffer.
//
// The head ("main") entry drives the e* outputs. The skid entry catches a
// bundle accepted while EX is stalled. dready is decoded only from the state
// register, so there is no combinational path from eready to dready.
//
// Ports
//   clk, clrn          clock (rising edge), async active-high reset
//   flush              synchronous kill of all held entries
//   dvalid / dready    decode-side handshake (dready = state != FULL)
//   d*                 decoded bundle: control bits, aluc, a, b, imm, pc4, rn
//   evalid / eready    execute-side handshake (pop = evalid & eready)
//   e*                 head bundle; ewreg/em2reg/ewmem/ejal are gated by evalid
//
// Optional macro PIPE_IDEX_PERF_EN adds stall_cnt, bubble_cnt and flush_cnt.
// These are saturating counters, cleared only by clrn.
module pipe_idex_hs_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CW   = 4,
  parameter int CNTW = 16
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          dvalid,
  output logic          dready,
  input  logic          dwreg,
  input  logic          dm2reg,
  input  logic          dwmem,
  input  logic          daluimm,
  input  logic          dshift,
  input  logic          djal,
  input  logic [CW-1:0] daluc,
  input  logic [DW-1:0] da,
  input  logic [DW-1:0] db,
  input  logic [DW-1:0] dimm,
  input  logic [DW-1:0] dpc4,
  input  logic [RW-1:0] drn,
  output logic          evalid,
  input  logic          eready,
`ifdef PIPE_IDEX_PERF_EN
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] bubble_cnt,
  output logic [CNTW-1:0] flush_cnt,
`endif
  output logic          ewreg,
  output logic          em2reg,
  output logic          ewmem,
  output logic          ealuimm,
  output logic          eshift,
  output logic          ejal,
  output logic [CW-1:0] ealuc,
  output logic [DW-1:0] ea,
  output logic [DW-1:0] eb,
  output logic [DW-1:0] eimm,
  output logic [DW-1:0] epc4,
  output logic [RW-1:0] ern
);

  localparam int BW = 6 + CW + 4*DW + RW;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   main_q, skid_q, dbus;
  logic            load_main, load_skid, main_from_skid;
  logic            acc, pop;
  logic            mwreg, mm2reg, mwmem, mjal;

  assign dbus   = {dwreg, dm2reg, dwmem, daluimm, dshift, djal,
                   daluc, da, db, dimm, dpc4, drn};
  assign dready = (state != FULL);
  assign evalid = (state != EMPTY);
  assign acc    = dvalid & dready;
  assign pop    = evalid & eready;

  // Next-state / entry-load control. flush overrides everything. Data
  // registers keep their old contents, and only validity is dropped.
  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc) begin
          state_nx  = BUSY;
          load_main = 1'b1;
        end
        BUSY: begin
          if (pop && acc)      load_main = 1'b1;
          else if (pop)        state_nx  = EMPTY;
          else if (acc) begin
            state_nx  = FULL;
            load_skid = 1'b1;
          end
        end
        FULL: if (pop) begin
          // Skid always holds the younger bundle, so it moves to the head.
          state_nx       = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (load_main) main_q <= main_from_skid ? skid_q : dbus;
      if (load_skid) skid_q <= dbus;
    end
  end

  assign {mwreg, mm2reg, mwmem, ealuimm, eshift, mjal,
          ealuc, ea, eb, eimm, epc4, ern} = main_q;

  // Bubbles must never write the register file or memory.
  assign ewreg  = mwreg  & evalid;
  assign em2reg = mm2reg & evalid;
  assign ewmem  = mwmem  & evalid;
  assign ejal   = mjal   & evalid;

`ifdef PIPE_IDEX_PERF_EN
  localparam logic [CNTW-1:0] CMAX = '1;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (evalid && !eready && stall_cnt != CMAX) stall_cnt <= stall_cnt + 1'b1;
      if (!evalid && !flush && bubble_cnt != CMAX) bubble_cnt <= bubble_cnt + 1'b1;
      if (flush && flush_cnt != CMAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule
